ow_reset_presence: RTL and testbench

Parametrised 1-Wire reset/presence engine. It owns the full reset slot: it checks the idle bus, drives the reset low pulse, and qualifies the slave presence pulse over a sampling window instead of a single sample. It also detects stuck-low and shorted-bus faults, supports standard and overdrive timing, and reports results through a start/done handshake to the 1-Wire master controller.

---
 rtl/ow_pkg.sv | 50 +++++
 rtl/ow_us_tick.sv | 38 +++
 rtl/ow_reset_presence.sv | 206 ++++++++++++++++++++
 tb/tb_ow_reset_presence.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ow_pkg.sv
// Shared types and default timing for the 1-Wire slot engines.
package ow_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        RESET_LOW = 3'd2,
        RELEASE   = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int TW = 16;

    typedef struct packed {
        logic [TW-1:0] reset_us;
        logic [TW-1:0] win_start_us;
        logic [TW-1:0] win_end_us;
        logic [TW-1:0] min_low_us;
        logic [TW-1:0] release_us;
    } timing_t;

    localparam int STD_RESET_US_DEF     = 480;
    localparam int STD_WIN_START_US_DEF = 15;
    localparam int STD_WIN_END_US_DEF   = 300;
    localparam int STD_MIN_LOW_US_DEF   = 60;
    localparam int STD_RELEASE_US_DEF   = 480;

    localparam int OD_RESET_US_DEF      = 70;
    localparam int OD_WIN_START_US_DEF  = 2;
    localparam int OD_WIN_END_US_DEF    = 24;
    localparam int OD_MIN_LOW_US_DEF    = 8;
    localparam int OD_RELEASE_US_DEF    = 48;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic timing_t make_timing(input int rst_us, input int ws_us,
                                            input int we_us, input int ml_us,
                                            input int rel_us);
        timing_t t;
        t.reset_us     = TW'(rst_us);
        t.win_start_us = TW'(ws_us);
        t.win_end_us   = TW'(we_us);
        t.min_low_us   = TW'(ml_us);
        t.release_us   = TW'(rel_us);
        return t;
    endfunction

endpackage

// File: rtl/ow_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US cycles, restarted by clr_i.
module ow_us_tick #(
    parameter int CLK_PER_US = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap at LAST; clear holds the count at zero so the first tick lands CLK_PER_US cycles later.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/ow_reset_presence.sv
// 1-Wire reset/presence slot engine: idle check, reset pulse, windowed presence qualification.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; results held
// CHECK     | wait one tick, then confirm the bus idles high
// RESET_LOW | drive the line low for reset_us ticks
// RELEASE   | line released; qualify presence inside the sampling window
// DONE      | one-cycle done pulse, results valid
module ow_reset_presence
    import ow_pkg::*;
#(
    parameter int CLK_PER_US       = 1,
    parameter int STD_RESET_US     = STD_RESET_US_DEF,
    parameter int STD_WIN_START_US = STD_WIN_START_US_DEF,
    parameter int STD_WIN_END_US   = STD_WIN_END_US_DEF,
    parameter int STD_MIN_LOW_US   = STD_MIN_LOW_US_DEF,
    parameter int STD_RELEASE_US   = STD_RELEASE_US_DEF,
    parameter int OD_RESET_US      = OD_RESET_US_DEF,
    parameter int OD_WIN_START_US  = OD_WIN_START_US_DEF,
    parameter int OD_WIN_END_US    = OD_WIN_END_US_DEF,
    parameter int OD_MIN_LOW_US    = OD_MIN_LOW_US_DEF,
    parameter int OD_RELEASE_US    = OD_RELEASE_US_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bus_i,
    input  logic start_i,
    input  logic overdrive_i,
    output logic master_pull_low_o,
    output logic busy_o,
    output logic done_o,
    output logic found_presence_o,
    output logic err_stuck_low_o,
    output logic err_short_o
);

    localparam int MAX_US = max2(max2(max2(STD_RESET_US, STD_RELEASE_US), STD_WIN_END_US),
                                 max2(max2(OD_RESET_US, OD_RELEASE_US), OD_WIN_END_US));
    localparam int UW      = $clog2(MAX_US + 1);
    localparam int MAX_MIN = max2(STD_MIN_LOW_US, OD_MIN_LOW_US);
    localparam int LW      = $clog2(MAX_MIN + 1);

    localparam timing_t TS_STD = make_timing(STD_RESET_US, STD_WIN_START_US, STD_WIN_END_US,
                                             STD_MIN_LOW_US, STD_RELEASE_US);
    localparam timing_t TS_OD  = make_timing(OD_RESET_US, OD_WIN_START_US, OD_WIN_END_US,
                                             OD_MIN_LOW_US, OD_RELEASE_US);

    state_t        state_q, state_d;
    logic          od_q, od_d;
    logic [UW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] low_q, low_d;
    logic          pres_q, pres_d;
    logic          found_q, found_d;
    logic          stuck_q, stuck_d;
    logic          short_q, short_d;
    logic          sync1_q, bus_s_q;
    logic          tick;

    timing_t       ts;
    logic [UW-1:0] reset_last;
    logic [UW-1:0] release_last;
    logic [UW-1:0] win_start;
    logic [UW-1:0] win_end;
    logic [LW-1:0] min_low;
    logic          in_window;

    ow_us_tick #(
        .CLK_PER_US(CLK_PER_US)
    ) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == IDLE),
        .tick_o(tick)
    );

    assign ts           = od_q ? TS_OD : TS_STD;
    assign reset_last   = UW'(ts.reset_us - TW'(1));
    assign release_last = UW'(ts.release_us - TW'(1));
    assign win_start    = UW'(ts.win_start_us);
    assign win_end      = UW'(ts.win_end_us);
    assign min_low      = LW'(ts.min_low_us);
    assign in_window    = (cnt_q >= win_start) && (cnt_q < win_end);

    // Two-flop synchronizer for the raw bus level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            bus_s_q <= 1'b0;
        end else begin
            sync1_q <= bus_i;
            bus_s_q <= sync1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            od_q    <= 1'b0;
            cnt_q   <= '0;
            low_q   <= '0;
            pres_q  <= 1'b0;
            found_q <= 1'b0;
            stuck_q <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            od_q    <= od_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            pres_q  <= pres_d;
            found_q <= found_d;
            stuck_q <= stuck_d;
            short_q <= short_d;
        end
    end

    // Next-state logic; the µs counter restarts on every state entry.
    always_comb begin
        state_d = state_q;
        od_d    = od_q;
        cnt_d   = cnt_q;
        low_d   = low_q;
        pres_d  = pres_q;
        found_d = found_q;
        stuck_d = stuck_q;
        short_d = short_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    od_d    = overdrive_i;
                    found_d = 1'b0;
                    stuck_d = 1'b0;
                    short_d = 1'b0;
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bus_s_q) begin
                        state_d = RESET_LOW;
                    end else begin
                        stuck_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RESET_LOW: begin
                if (tick) begin
                    if (cnt_q == reset_last) begin
                        cnt_d   = '0;
                        low_d   = '0;
                        pres_d  = 1'b0;
                        state_d = RELEASE;
                    end else begin
                        cnt_d = cnt_q + UW'(1);
                    end
                end
            end
            RELEASE: begin
                if (tick) begin
                    // Lows outside the window never count, so a pulse starting early is measured from win_start.
                    if (in_window && !bus_s_q) begin
                        if (low_q != min_low) begin
                            low_d = low_q + LW'(1);
                        end
                        if (low_d == min_low) begin
                            pres_d = 1'b1;
                        end
                    end else begin
                        low_d = '0;
                    end
                    if (cnt_q == release_last) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        if (!bus_s_q) begin
                            short_d = 1'b1;
                            found_d = 1'b0;
                        end else begin
                            found_d = pres_d;
                        end
                    end else begin
                        cnt_d = cnt_q + UW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign master_pull_low_o = (state_q == RESET_LOW);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = (state_q == DONE);
    assign found_presence_o  = found_q;
    assign err_stuck_low_o   = stuck_q;
    assign err_short_o       = short_q;

endmodule

// File: tb/tb_ow_reset_presence.sv
// Directed bench for ow_reset_presence with an open-drain slave model on the bus.
module tb_ow_reset_presence;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic bus_i = 1'b1;
    logic start_i = 1'b0;
    logic overdrive_i = 1'b0;
    logic master_pull_low_o;
    logic busy_o;
    logic done_o;
    logic found_presence_o;
    logic err_stuck_low_o;
    logic err_short_o;

    int checks = 0;
    int failures = 0;

    ow_reset_presence dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .bus_i            (bus_i),
        .start_i          (start_i),
        .overdrive_i      (overdrive_i),
        .master_pull_low_o(master_pull_low_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .found_presence_o (found_presence_o),
        .err_stuck_low_o  (err_stuck_low_o),
        .err_short_o      (err_short_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit od;
        bit stuck;
        bit poke;
        int lo_start;
        int lo_len;
        bit e_found;
        bit e_stuck;
        bit e_short;
        int e_done;
        int e_pull;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Run one slot. Level index k = value seen in the cycle ending at edge A+k.
    task automatic run_slot(input vec_t v, input int idx);
        int  done_at;
        int  pull_first;
        int  pull_cnt;
        int  busy_first;
        int  rel_at;
        int  r;
        int  k;
        bit  seen_pull;
        bit  released;
        bit  slave;
        done_at = -1; pull_first = -1; pull_cnt = 0; busy_first = -1;
        rel_at = 0; seen_pull = 0; released = 0;
        bus_i = !v.stuck;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        overdrive_i = v.od;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        overdrive_i = !v.od;
        k = 1;
        while (k <= 1500) begin
            if (k == 1) begin
                chk($sformatf("v%0d_clr_found", idx), found_presence_o, 0);
                chk($sformatf("v%0d_clr_stuck", idx), err_stuck_low_o, 0);
                chk($sformatf("v%0d_clr_short", idx), err_short_o, 0);
            end
            if (busy_o && busy_first < 0) busy_first = k;
            if (master_pull_low_o) begin
                pull_cnt++;
                if (pull_first < 0) pull_first = k;
                seen_pull = 1;
            end
            if (done_o && done_at < 0) done_at = k;
            if (!released && seen_pull && !master_pull_low_o) begin
                released = 1;
                rel_at = k;
            end
            r = k - rel_at;
            slave = v.stuck || (released && r >= v.lo_start && r < v.lo_start + v.lo_len);
            bus_i = !(master_pull_low_o || slave);
            start_i = (v.poke && k == 600);
            if (done_at >= 0) break;
            @(posedge clk_i);
            #1;
            k++;
        end
        start_i = 1'b0;
        chk($sformatf("v%0d_done_at", idx), done_at, v.e_done);
        chk($sformatf("v%0d_busy_first", idx), busy_first, 1);
        chk($sformatf("v%0d_pull_cnt", idx), pull_cnt, v.e_pull);
        if (v.e_pull > 0) chk($sformatf("v%0d_pull_first", idx), pull_first, 2);
        @(posedge clk_i);
        #1;
        bus_i = 1'b1;
        chk($sformatf("v%0d_done_width", idx), done_o, 0);
        chk($sformatf("v%0d_busy_fall", idx), busy_o, 0);
        chk($sformatf("v%0d_found", idx), found_presence_o, v.e_found);
        chk($sformatf("v%0d_stuck", idx), err_stuck_low_o, v.e_stuck);
        chk($sformatf("v%0d_short", idx), err_short_o, v.e_short);
        repeat (3) @(posedge clk_i);
        #1;
        chk($sformatf("v%0d_found_hold", idx), found_presence_o, v.e_found);
    endtask

    initial begin
        vec_t nv;
        //          od st pk start len  fnd stk sht done pull
        vecs[0]  = '{0, 0, 0,  30, 120,   1, 0, 0, 962, 480};
        vecs[1]  = '{0, 0, 0,   0,   0,   0, 0, 0, 962, 480};
        vecs[2]  = '{0, 1, 0,   0,   0,   0, 1, 0,   2,   0};
        vecs[3]  = '{0, 0, 0,   0, 10000, 0, 0, 1, 962, 480};
        vecs[4]  = '{1, 0, 0,   3,  10,   1, 0, 0, 120,  70};
        vecs[5]  = '{0, 0, 0,  30,  40,   0, 0, 0, 962, 480};
        vecs[6]  = '{0, 0, 0,   0,  72,   0, 0, 0, 962, 480};
        vecs[7]  = '{0, 0, 0,   0,  73,   1, 0, 0, 962, 480};
        vecs[8]  = '{0, 0, 0, 238,  60,   1, 0, 0, 962, 480};
        vecs[9]  = '{0, 0, 0, 239,  60,   0, 0, 0, 962, 480};
        vecs[10] = '{1, 0, 0,   0,   0,   0, 0, 0, 120,  70};
        vecs[11] = '{0, 0, 1,  30, 120,   1, 0, 0, 962, 480};

        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_pull", master_pull_low_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_found", found_presence_o, 0);
        chk("rst_stuck", err_stuck_low_o, 0);
        chk("rst_short", err_short_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_slot(vecs[i], i);
        end

        // Reset in the middle of the reset pulse, then a normal slot.
        bus_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        overdrive_i = 1'b0;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (99) @(posedge clk_i);
        #1;
        chk("midrst_pulling", master_pull_low_o, 1);
        chk("midrst_found_before", found_presence_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("midrst_pull", master_pull_low_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        rst_i = 1'b0;
        nv = '{0, 0, 0, 30, 40, 0, 0, 0, 962, 480};
        run_slot(nv, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
